// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - RV32I opcode, ALU and control-select encodings for control_hazard_unit
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [5:0] ALU_ADD       = 6'b000000;
   localparam logic [5:0] ALU_PASS_A    = 6'b011111;
   localparam logic [2:0] ALU_BRANCH_HI = 3'b010;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_TARGET = 2'b01,
      NPC_HOLD   = 2'b10
   } next_pc_sel_e;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'b00,
      OPA_PC   = 2'b01,
      OPA_PC4  = 2'b10,
      OPA_ZERO = 2'b11
   } operand_a_sel_e;

   typedef enum logic [1:0] {
      EXT_I = 2'b00,
      EXT_S = 2'b01,
      EXT_U = 2'b10,
      EXT_B = 2'b11
   } extend_sel_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - i-mem, d-mem and control-flow hazard flags
// Flags are purely combinational so reset never masks them.
module hazard_detect
   import ctrl_pkg::*;
#(
   parameter int ADDRESS_BITS = 20
) (
   input  logic [6:0]              opcode_decode,
   input  logic [6:0]              opcode_execute,
   input  logic                    branch_execute,
   input  logic                    fetch_valid,
   input  logic                    fetch_ready,
   input  logic [ADDRESS_BITS-1:0] issue_PC,
   input  logic [ADDRESS_BITS-1:0] fetch_address_in,
   input  logic                    memory_valid,
   input  logic                    memory_ready,
   input  logic                    load_memory,
   input  logic                    store_memory,
   input  logic [ADDRESS_BITS-1:0] load_address,
   input  logic [ADDRESS_BITS-1:0] memory_address_in,
   output logic                    i_mem_hazard,
   output logic                    d_mem_issue_hazard,
   output logic                    d_mem_recv_hazard,
   output logic                    JALR_branch_hazard,
   output logic                    JAL_hazard
);

   assign i_mem_hazard       = ~fetch_ready | (fetch_valid & (fetch_address_in != issue_PC));
   assign d_mem_issue_hazard = (load_memory | store_memory) & ~memory_ready;
   assign d_mem_recv_hazard  = load_memory & (~memory_valid | (memory_address_in != load_address));
   assign JALR_branch_hazard = (opcode_execute == OP_JALR) |
                               ((opcode_execute == OP_BRANCH) & branch_execute);
   assign JAL_hazard         = (opcode_decode == OP_JAL);

endmodule

// File: rtl/control_hazard_unit.sv
// rtl/control_hazard_unit.sv - RV32I decode/control, hazard handling and next-PC select
// Optional CTRL_SCAN_DEBUG_EN adds a free-running cycle counter with scan-windowed debug prints.
module control_hazard_unit
   import ctrl_pkg::*;
#(
   parameter int CORE            = 0,
   parameter int ADDRESS_BITS    = 20,
   parameter int NUM_BYTES       = 4,
   parameter int LOG2_NUM_BYTES  = $clog2(NUM_BYTES),
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [6:0]                opcode_decode,
   input  logic [6:0]                opcode_execute,
   input  logic [2:0]                funct3,
   input  logic [6:0]                funct7,
   input  logic [ADDRESS_BITS-1:0]   JALR_target_execute,
   input  logic [ADDRESS_BITS-1:0]   branch_target_execute,
   input  logic [ADDRESS_BITS-1:0]   JAL_target_decode,
   input  logic                      branch_execute,
   input  logic                      true_data_hazard,
   input  logic                      fetch_valid,
   input  logic                      fetch_ready,
   input  logic                      issue_request,
   input  logic [ADDRESS_BITS-1:0]   issue_PC,
   input  logic [ADDRESS_BITS-1:0]   fetch_address_in,
   input  logic                      memory_valid,
   input  logic                      memory_ready,
   input  logic                      load_memory,
   input  logic                      store_memory,
   input  logic [ADDRESS_BITS-1:0]   load_address,
   input  logic [ADDRESS_BITS-1:0]   memory_address_in,
   input  logic                      scan,
   output logic                      branch_op,
   output logic                      memRead,
   output logic [5:0]                ALU_operation,
   output logic                      memWrite,
   output logic [LOG2_NUM_BYTES-1:0] log2_bytes,
   output logic                      unsigned_load,
   output logic [1:0]                next_PC_sel,
   output logic [1:0]                operand_A_sel,
   output logic                      operand_B_sel,
   output logic [1:0]                extend_sel,
   output logic                      regWrite,
   output logic [ADDRESS_BITS-1:0]   target_PC,
   output logic                      i_mem_read,
   output logic                      i_mem_hazard,
   output logic                      d_mem_issue_hazard,
   output logic                      d_mem_recv_hazard,
   output logic                      JALR_branch_hazard,
   output logic                      JAL_hazard
);

   logic stall_hold;
   logic redirect;

   hazard_detect #(
      .ADDRESS_BITS (ADDRESS_BITS)
   ) u_hazard_detect (
      .opcode_decode      (opcode_decode),
      .opcode_execute     (opcode_execute),
      .branch_execute     (branch_execute),
      .fetch_valid        (fetch_valid),
      .fetch_ready        (fetch_ready),
      .issue_PC           (issue_PC),
      .fetch_address_in   (fetch_address_in),
      .memory_valid       (memory_valid),
      .memory_ready       (memory_ready),
      .load_memory        (load_memory),
      .store_memory       (store_memory),
      .load_address       (load_address),
      .memory_address_in  (memory_address_in),
      .i_mem_hazard       (i_mem_hazard),
      .d_mem_issue_hazard (d_mem_issue_hazard),
      .d_mem_recv_hazard  (d_mem_recv_hazard),
      .JALR_branch_hazard (JALR_branch_hazard),
      .JAL_hazard         (JAL_hazard)
   );

   assign stall_hold = d_mem_issue_hazard | d_mem_recv_hazard | true_data_hazard;
   assign redirect   = JALR_branch_hazard | JAL_hazard;

   always_comb begin
      if (opcode_execute == OP_JALR)
         target_PC = JALR_target_execute;
      else if ((opcode_execute == OP_BRANCH) && branch_execute)
         target_PC = branch_target_execute;
      else
         target_PC = JAL_target_decode;
   end

   always_comb begin
      branch_op     = 1'b0;
      memRead       = 1'b0;
      memWrite      = 1'b0;
      regWrite      = 1'b0;
      unsigned_load = 1'b0;
      operand_B_sel = 1'b0;
      ALU_operation = ALU_ADD;
      log2_bytes    = '0;
      operand_A_sel = OPA_RS1;
      extend_sel    = EXT_I;

      case (opcode_decode)
         OP_R: begin
            regWrite      = 1'b1;
            ALU_operation = {2'b00, funct7[5], funct3};
         end
         OP_I: begin
            regWrite      = 1'b1;
            operand_B_sel = 1'b1;
            // Only shift-immediates carry the arithmetic/logical bit in funct7.
            ALU_operation = (funct3[1:0] == 2'b01) ? {2'b00, funct7[5], funct3}
                                                   : {3'b000, funct3};
         end
         OP_LOAD: begin
            regWrite      = 1'b1;
            memRead       = 1'b1;
            operand_B_sel = 1'b1;
            log2_bytes    = LOG2_NUM_BYTES'(funct3[1:0]);
            unsigned_load = funct3[2];
         end
         OP_STORE: begin
            memWrite      = 1'b1;
            operand_B_sel = 1'b1;
            log2_bytes    = LOG2_NUM_BYTES'(funct3[1:0]);
            extend_sel    = EXT_S;
         end
         OP_BRANCH: begin
            branch_op     = 1'b1;
            ALU_operation = {ALU_BRANCH_HI, funct3};
            extend_sel    = EXT_B;
         end
         OP_JAL, OP_JALR: begin
            regWrite      = 1'b1;
            ALU_operation = ALU_PASS_A;
            operand_A_sel = OPA_PC4;
         end
         OP_LUI: begin
            regWrite      = 1'b1;
            operand_B_sel = 1'b1;
            operand_A_sel = OPA_ZERO;
            extend_sel    = EXT_U;
         end
         OP_AUIPC: begin
            regWrite      = 1'b1;
            operand_B_sel = 1'b1;
            operand_A_sel = OPA_PC;
            extend_sel    = EXT_U;
         end
         default: ;
      endcase

      if (true_data_hazard) begin
         regWrite  = 1'b0;
         memRead   = 1'b0;
         memWrite  = 1'b0;
         branch_op = 1'b0;
      end

      if (stall_hold)
         next_PC_sel = NPC_HOLD;
      else if (redirect)
         next_PC_sel = NPC_TARGET;
      else if (i_mem_hazard)
         next_PC_sel = NPC_HOLD;
      else
         next_PC_sel = NPC_PLUS4;

      i_mem_read = ~stall_hold;

      // Reset gates every state-changing control immediately, without waiting for a clock.
      if (reset) begin
         regWrite    = 1'b0;
         memRead     = 1'b0;
         memWrite    = 1'b0;
         branch_op   = 1'b0;
         i_mem_read  = 1'b0;
         next_PC_sel = NPC_PLUS4;
      end
   end

   logic unused_fields;
   assign unused_fields = ^{funct7[6], funct7[4:0], issue_request};

`ifdef CTRL_SCAN_DEBUG_EN
   logic [31:0] cycle_q;
   logic [31:0] cycle_d;

   assign cycle_d = cycle_q + 32'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cycle_q <= 32'd0;
      else
         cycle_q <= cycle_d;
   end

   always_ff @(posedge clock) begin
      if (scan && (cycle_q >= 32'(SCAN_CYCLES_MIN)) && (cycle_q <= 32'(SCAN_CYCLES_MAX))) begin
         $display("core %0d cycle %0d: i_mem %b d_issue %b d_recv %b jalr_br %b jal %b next_PC_sel %b target_PC %h",
                  CORE, cycle_q, i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
                  JALR_branch_hazard, JAL_hazard, next_PC_sel, target_PC);
      end
   end
`else
   localparam int unused_dbg_params = CORE + SCAN_CYCLES_MIN + SCAN_CYCLES_MAX;
   logic unused_dbg;
   assign unused_dbg = ^{clock, scan};
`endif

endmodule

// File: tb/tb_control_hazard_unit.sv
// tb/tb_control_hazard_unit.sv - scoreboard bench for control_hazard_unit with directed vectors
module tb_control_hazard_unit;

   typedef struct packed {
      logic        branch_op;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        unsigned_load;
      logic        op_b;
      logic        i_mem_read;
      logic [5:0]  alu;
      logic [1:0]  log2b;
      logic [1:0]  npc;
      logic [1:0]  op_a;
      logic [1:0]  ext;
      logic [19:0] target;
      logic        h_imem;
      logic        h_dissue;
      logic        h_drecv;
      logic        h_jalr_br;
      logic        h_jal;
   } out_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  opcode_decode, opcode_execute;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [19:0] JALR_target_execute, branch_target_execute, JAL_target_decode;
   logic        branch_execute, true_data_hazard;
   logic        fetch_valid, fetch_ready, issue_request;
   logic [19:0] issue_PC, fetch_address_in;
   logic        memory_valid, memory_ready, load_memory, store_memory;
   logic [19:0] load_address, memory_address_in;
   logic        scan;

   logic        branch_op, memRead, memWrite, regWrite, unsigned_load, operand_B_sel, i_mem_read;
   logic [5:0]  ALU_operation;
   logic [1:0]  log2_bytes, next_PC_sel, operand_A_sel, extend_sel;
   logic [19:0] target_PC;
   logic        i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard, JALR_branch_hazard, JAL_hazard;

   out_t  exp_q[$];
   string name_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   always #5 clock = ~clock;

   control_hazard_unit dut (
      .clock                 (clock),
      .reset                 (reset),
      .opcode_decode         (opcode_decode),
      .opcode_execute        (opcode_execute),
      .funct3                (funct3),
      .funct7                (funct7),
      .JALR_target_execute   (JALR_target_execute),
      .branch_target_execute (branch_target_execute),
      .JAL_target_decode     (JAL_target_decode),
      .branch_execute        (branch_execute),
      .true_data_hazard      (true_data_hazard),
      .fetch_valid           (fetch_valid),
      .fetch_ready           (fetch_ready),
      .issue_request         (issue_request),
      .issue_PC              (issue_PC),
      .fetch_address_in      (fetch_address_in),
      .memory_valid          (memory_valid),
      .memory_ready          (memory_ready),
      .load_memory           (load_memory),
      .store_memory          (store_memory),
      .load_address          (load_address),
      .memory_address_in     (memory_address_in),
      .scan                  (scan),
      .branch_op             (branch_op),
      .memRead               (memRead),
      .ALU_operation         (ALU_operation),
      .memWrite              (memWrite),
      .log2_bytes            (log2_bytes),
      .unsigned_load         (unsigned_load),
      .next_PC_sel           (next_PC_sel),
      .operand_A_sel         (operand_A_sel),
      .operand_B_sel         (operand_B_sel),
      .extend_sel            (extend_sel),
      .regWrite              (regWrite),
      .target_PC             (target_PC),
      .i_mem_read            (i_mem_read),
      .i_mem_hazard          (i_mem_hazard),
      .d_mem_issue_hazard    (d_mem_issue_hazard),
      .d_mem_recv_hazard     (d_mem_recv_hazard),
      .JALR_branch_hazard    (JALR_branch_hazard),
      .JAL_hazard            (JAL_hazard)
   );

   // Monitor: the stimulus side offers one settled output set per clock period.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         out_t  e, a;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = '{branch_op, memRead, memWrite, regWrite, unsigned_load, operand_B_sel, i_mem_read,
               ALU_operation, log2_bytes, next_PC_sel, operand_A_sel, extend_sel, target_PC,
               i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard, JALR_branch_hazard, JAL_hazard};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (br memR memW regW uns opB imr alu log2 npc opA ext target hI hDi hDr hJB hJ)",
                     n, a, e);
         end
      end
   end

   task automatic idle();
      opcode_decode = 7'h00; opcode_execute = 7'h00; funct3 = 3'b000; funct7 = 7'h00;
      JALR_target_execute = 20'h0; branch_target_execute = 20'h0; JAL_target_decode = 20'h0;
      branch_execute = 1'b0; true_data_hazard = 1'b0;
      fetch_valid = 1'b0; fetch_ready = 1'b1; issue_request = 1'b1;
      issue_PC = 20'h0; fetch_address_in = 20'h0;
      memory_valid = 1'b0; memory_ready = 1'b1; load_memory = 1'b0; store_memory = 1'b0;
      load_address = 20'h0; memory_address_in = 20'h0; scan = 1'b0;
   endtask

   function automatic out_t base();
      out_t e;
      e = '0;
      e.i_mem_read = 1'b1;
      return e;
   endfunction

   task automatic expect_out(input string n, input out_t e);
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clock);
      #1;
   endtask

   initial begin
      out_t e;
      idle();
      reset = 1'b1;
      opcode_decode = 7'b0110011;
      @(posedge clock); #1;

      e = base(); e.i_mem_read = 1'b0;
      expect_out("reset_state", e);

      reset = 1'b0;
      idle(); opcode_decode = 7'b0110011;
      e = base(); e.reg_write = 1'b1;
      expect_out("r_add", e);

      idle(); opcode_decode = 7'b0110011; funct7 = 7'b0100000;
      e = base(); e.reg_write = 1'b1; e.alu = 6'b001000;
      expect_out("r_sub", e);

      idle(); opcode_decode = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0100000;
      e = base(); e.reg_write = 1'b1; e.op_b = 1'b1; e.alu = 6'b001101;
      expect_out("i_srai", e);

      idle(); opcode_decode = 7'b0010011; funct3 = 3'b100; funct7 = 7'b0100000;
      e = base(); e.reg_write = 1'b1; e.op_b = 1'b1; e.alu = 6'b000100;
      expect_out("i_xori", e);

      idle(); opcode_decode = 7'b0000011; funct3 = 3'b010; load_memory = 1'b1;
      e = base(); e.reg_write = 1'b1; e.mem_read = 1'b1; e.op_b = 1'b1; e.log2b = 2'd2;
      e.h_drecv = 1'b1; e.npc = 2'b10; e.i_mem_read = 1'b0;
      expect_out("lw_recv_wait", e);

      idle(); opcode_decode = 7'b0000011; funct3 = 3'b100; load_memory = 1'b1;
      memory_valid = 1'b1; load_address = 20'h00200; memory_address_in = 20'h00200;
      e = base(); e.reg_write = 1'b1; e.mem_read = 1'b1; e.op_b = 1'b1; e.unsigned_load = 1'b1;
      expect_out("lbu_ok", e);

      idle(); load_memory = 1'b1; memory_valid = 1'b1;
      load_address = 20'h00200; memory_address_in = 20'h00204;
      e = base(); e.h_drecv = 1'b1; e.npc = 2'b10; e.i_mem_read = 1'b0;
      expect_out("load_addr_mismatch", e);

      idle(); opcode_decode = 7'b0100011; funct3 = 3'b001; store_memory = 1'b1; memory_ready = 1'b0;
      e = base(); e.mem_write = 1'b1; e.op_b = 1'b1; e.log2b = 2'd1; e.ext = 2'b01;
      e.h_dissue = 1'b1; e.npc = 2'b10; e.i_mem_read = 1'b0;
      expect_out("store_issue_wait", e);

      idle(); opcode_decode = 7'b1100011; funct3 = 3'b001;
      opcode_execute = 7'b1100011; branch_execute = 1'b1; branch_target_execute = 20'h00100;
      JAL_target_decode = 20'h00040;
      e = base(); e.branch_op = 1'b1; e.alu = 6'b010001; e.ext = 2'b11;
      e.h_jalr_br = 1'b1; e.target = 20'h00100; e.npc = 2'b01;
      expect_out("branch_taken", e);

      branch_execute = 1'b0;
      e = base(); e.branch_op = 1'b1; e.alu = 6'b010001; e.ext = 2'b11; e.target = 20'h00040;
      expect_out("branch_not_taken", e);

      idle(); opcode_decode = 7'b0010111; opcode_execute = 7'b1100111;
      JALR_target_execute = 20'h0ABCD; branch_target_execute = 20'h00100; branch_execute = 1'b1;
      e = base(); e.reg_write = 1'b1; e.op_b = 1'b1; e.op_a = 2'b01; e.ext = 2'b10;
      e.h_jalr_br = 1'b1; e.target = 20'h0ABCD; e.npc = 2'b01;
      expect_out("jalr_exec_auipc", e);

      idle(); opcode_decode = 7'b1101111; JAL_target_decode = 20'h00040; fetch_ready = 1'b0;
      e = base(); e.reg_write = 1'b1; e.alu = 6'b011111; e.op_a = 2'b10;
      e.h_jal = 1'b1; e.h_imem = 1'b1; e.npc = 2'b01; e.target = 20'h00040;
      expect_out("jal_over_imem", e);

      idle(); opcode_decode = 7'b0110111; fetch_valid = 1'b1;
      fetch_address_in = 20'h00010; issue_PC = 20'h00014;
      e = base(); e.reg_write = 1'b1; e.op_b = 1'b1; e.op_a = 2'b11; e.ext = 2'b10;
      e.h_imem = 1'b1; e.npc = 2'b10;
      expect_out("imem_addr_mismatch_lui", e);

      idle(); opcode_decode = 7'b0100011; funct3 = 3'b010; true_data_hazard = 1'b1;
      e = base(); e.op_b = 1'b1; e.log2b = 2'd2; e.ext = 2'b01; e.npc = 2'b10; e.i_mem_read = 1'b0;
      expect_out("store_true_hazard", e);

      idle(); opcode_decode = 7'b1101111; JAL_target_decode = 20'h00080; load_memory = 1'b1;
      e = base(); e.reg_write = 1'b1; e.alu = 6'b011111; e.op_a = 2'b10; e.h_jal = 1'b1;
      e.h_drecv = 1'b1; e.npc = 2'b10; e.i_mem_read = 1'b0; e.target = 20'h00080;
      expect_out("hold_beats_jal", e);

      idle(); opcode_decode = 7'b1111111; funct3 = 3'b111; funct7 = 7'h7F;
      e = base();
      expect_out("unknown_opcode", e);

      idle(); opcode_decode = 7'b1100111;
      e = base(); e.reg_write = 1'b1; e.alu = 6'b011111; e.op_a = 2'b10;
      expect_out("jalr_decode", e);

      idle(); opcode_decode = 7'b0100011; funct3 = 3'b010; fetch_ready = 1'b0;
      #2 reset = 1'b1;
      e = base(); e.op_b = 1'b1; e.log2b = 2'd2; e.ext = 2'b01; e.h_imem = 1'b1; e.i_mem_read = 1'b0;
      expect_out("reset_mid_store", e);

      reset = 1'b0;
      idle(); opcode_decode = 7'b0110011;
      e = base(); e.reg_write = 1'b1;
      expect_out("after_reset_r_add", e);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
